pipe_ctrl: RTL and testbench

- Central sequencing controller for the three-stage pipeline.
- Drives the Fetch stage controls `PC_sel`, `flush`, `stall` and `epc_taken` from the following events:
  - branch/jump resolution in stage 2;
  - a multi-cycle data-memory handshake;
  - external interrupt entry;
  - `mret` return.
- Sits beside the datapath top level, between the execute/memory stage, the CSR file and Fetch.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl_mem_wait_timer.sv | 27 ++
 rtl/pipe_ctrl.sv | 104 ++++++++++
 tb/tb_pipe_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    TRAP_SAVE = 2'd2,
    TRAP_JUMP = 2'd3
  } pipe_state_e;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-2 / CSR / Fetch handshake bundle around pipe_ctrl.
// master = datapath side driving events, slave = the controller.
interface pipe_ctrl_if #(parameter int unsigned CNT_W = 32);
  logic             br_taken_i;
  logic             jump_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             irq_i;
  logic             irq_en_i;
  logic             mret_i;
  logic             PC_sel;
  logic             flush;
  logic             stall;
  logic             epc_taken;
  logic             trap_enter_o;
  logic             mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output br_taken_i, jump_i, mem_req_i, mem_ack_i, irq_i, irq_en_i, mret_i,
    input  PC_sel, flush, stall, epc_taken, trap_enter_o, mem_err_o, stall_cnt_o
  );

  modport slave (
    input  br_taken_i, jump_i, mem_req_i, mem_ack_i, irq_i, irq_en_i, mret_i,
    output PC_sel, flush, stall, epc_taken, trap_enter_o, mem_err_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_mem_wait_timer.sv
// Data-memory wait timer: counts stalled wait cycles and flags expiry.
module mem_wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic expired
);
  localparam int unsigned W = $clog2(MEM_TIMEOUT) + 1;

  logic [W-1:0] cnt;

  // The request cycle counts as wait cycle 0, so the count seen in the
  // k-th stall cycle is k and expiry lands on cycle MEM_TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (rst)        cnt <= '0;
    else if (start) cnt <= W'(1);
    else if (run)   cnt <= cnt + W'(1);
    else            cnt <= '0;
  end

  assign expired = (cnt == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: redirect, memory stall, irq entry, mret.
// Optional bus-error timeout on memory waits under `MEM_TIMEOUT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);
  pipe_state_e      state, state_nxt;
  logic             pc_sel, flush, stall, epc_taken, trap_enter, mem_err;
  logic             expired;
  logic [CNT_W-1:0] stall_cnt;

`ifdef MEM_TIMEOUT_EN
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (state == RUN && stall),
    .run     (state == MEM_WAIT && stall),
    .expired (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = |MEM_TIMEOUT;
  assign expired        = 1'b0;
`endif

  // Outputs are decoded from state and live inputs: redirects must act in
  // the same cycle stage 2 resolves them.
  always_comb begin
    state_nxt  = state;
    pc_sel     = 1'b0;
    flush      = 1'b0;
    stall      = 1'b0;
    epc_taken  = 1'b0;
    trap_enter = 1'b0;
    mem_err    = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (bus.mem_req_i) begin
            if (!bus.mem_ack_i) begin
              stall     = 1'b1;
              state_nxt = MEM_WAIT;
            end
          end else if (bus.br_taken_i || bus.jump_i) begin
            pc_sel = 1'b1;
            flush  = 1'b1;
          end else if (bus.mret_i) begin
            epc_taken = 1'b1;
            flush     = 1'b1;
          end else if (bus.irq_i && bus.irq_en_i) begin
            stall      = 1'b1;
            trap_enter = 1'b1;
            state_nxt  = TRAP_SAVE;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ack_i) begin
            state_nxt = RUN;
          end else if (expired) begin
            mem_err   = 1'b1;
            flush     = 1'b1;
            state_nxt = RUN;
          end else begin
            stall = 1'b1;
          end
        end
        TRAP_SAVE: begin
          stall     = 1'b1;
          state_nxt = TRAP_JUMP;
        end
        TRAP_JUMP: begin
          epc_taken = 1'b1;
          flush     = 1'b1;
          state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.PC_sel       = pc_sel;
  assign bus.flush        = flush;
  assign bus.stall        = stall;
  assign bus.epc_taken    = epc_taken;
  assign bus.trap_enter_o = trap_enter;
  assign bus.mem_err_o    = mem_err;
  assign bus.stall_cnt_o  = stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, then random stimulus vs model.
module tb_pipe_ctrl;
  localparam int CW = 4;
  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // in  = {rst, br, jump, req, ack, irq, irq_en, mret}
  // exp = {PC_sel, flush, stall, epc_taken, trap_enter, mem_err}
  typedef struct {
    string      name;
    logic [7:0] in;
    logic [5:0] f;
    int         c;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  bit m_wait;
  int m_waited, m_trap, m_cnt;

  function automatic vec_t v(string n, logic [7:0] in, logic [5:0] f, int c);
    vec_t t;
    t.name = n; t.in = in; t.f = f; t.c = c;
    return t;
  endfunction

  task automatic drive(input logic [7:0] in);
    rst = in[7];
    {bus.br_taken_i, bus.jump_i, bus.mem_req_i, bus.mem_ack_i,
     bus.irq_i, bus.irq_en_i, bus.mret_i} = in[6:0];
    assert ($countones({in[6], in[5], in[4], in[0]}) <= 1)
      else $error("illegal stage-2 combination %b", in);
  endtask

  task automatic check(input string nm, input logic [5:0] ef, input int ec);
    logic [5:0] got;
    @(negedge clk);
    got = {bus.PC_sel, bus.flush, bus.stall, bus.epc_taken, bus.trap_enter_o, bus.mem_err_o};
    total++;
    if (got !== ef || bus.stall_cnt_o !== CW'(ec) || (bus.PC_sel && bus.epc_taken)) begin
      bad++;
      $display("FAIL %s @%0t: flags got %b want %b, stall_cnt got %0d want %0d",
               nm, $time, got, ef, bus.stall_cnt_o, ec);
    end
    @(posedge clk);
    #1;
  endtask

  // Reference: tracks wait length and trap phase as plain counters.
  task automatic model_eval(input logic [7:0] in, output logic [5:0] f);
    logic r, br, jp, rq, ak, iq, ie, mr;
    {r, br, jp, rq, ak, iq, ie, mr} = in;
    f = '0;
    if (r) begin
      m_wait = 0; m_trap = 0; m_cnt = 0;
      return;
    end
    if (m_trap == 1) begin
      f[3] = 1; m_trap = 2;
    end else if (m_trap == 2) begin
      f[4] = 1; f[2] = 1; m_trap = 0;
    end else if (m_wait) begin
      if (ak) m_wait = 0;
      else if (TO_EN && m_waited == TO - 1) begin
        f[4] = 1; f[0] = 1; m_wait = 0;
      end else begin
        f[3] = 1; m_waited++;
      end
    end else if (rq) begin
      if (!ak) begin f[3] = 1; m_wait = 1; m_waited = 1; end
    end else if (br || jp) f[5:4] = 2'b11;
    else if (mr) begin f[4] = 1; f[2] = 1; end
    else if (iq && ie) begin f[3] = 1; f[1] = 1; m_trap = 1; end
    if (f[3]) m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  initial begin
    logic [5:0] ef;
    logic [7:0] in;
    int ec;

    tbl.push_back(v("rst",        8'b1000_0000, 6'b000000, 0));
    tbl.push_back(v("idle",       8'b0000_0000, 6'b000000, 0));
    tbl.push_back(v("zero_wait",  8'b0001_1000, 6'b000000, 0));
    tbl.push_back(v("zw_after",   8'b0000_0000, 6'b000000, 0));
    tbl.push_back(v("wait0",      8'b0001_0000, 6'b001000, 0));
    tbl.push_back(v("wait1",      8'b0000_0000, 6'b001000, 1));
    tbl.push_back(v("wait2",      8'b0000_0000, 6'b001000, 2));
    tbl.push_back(v("wait_ack",   8'b0000_1000, 6'b000000, 3));
    tbl.push_back(v("idle2",      8'b0000_0000, 6'b000000, 3));
    tbl.push_back(v("br_irq",     8'b0100_0110, 6'b110000, 3));
    tbl.push_back(v("irq_take",   8'b0000_0110, 6'b001010, 3));
    tbl.push_back(v("trap_save",  8'b0000_0110, 6'b001000, 4));
    tbl.push_back(v("trap_jump",  8'b0000_0110, 6'b010100, 5));
    tbl.push_back(v("irq_masked", 8'b0000_0100, 6'b000000, 5));
    tbl.push_back(v("mret",       8'b0000_0001, 6'b010100, 5));
    tbl.push_back(v("after_mret", 8'b0000_0000, 6'b000000, 5));
    tbl.push_back(v("jump",       8'b0010_0000, 6'b110000, 5));
    tbl.push_back(v("rw0",        8'b0001_0000, 6'b001000, 5));
    tbl.push_back(v("rw1",        8'b0000_0000, 6'b001000, 6));
    tbl.push_back(v("rst_mid",    8'b1000_0000, 6'b000000, 7));
    tbl.push_back(v("post_rst",   8'b0000_0000, 6'b000000, 0));
    tbl.push_back(v("br_redir",   8'b0100_0000, 6'b110000, 0));
    tbl.push_back(v("to0",        8'b0001_0000, 6'b001000, 0));
    tbl.push_back(v("to1",        8'b0000_0000, 6'b001000, 1));
    tbl.push_back(v("to2",        8'b0000_0000, 6'b001000, 2));
    tbl.push_back(v("to3",        8'b0000_0000, TO_EN ? 6'b010001 : 6'b001000, 3));
    tbl.push_back(v("to4",        8'b0000_0000, TO_EN ? 6'b000000 : 6'b001000, TO_EN ? 3 : 4));
    tbl.push_back(v("to_rst",     8'b1000_0000, 6'b000000, TO_EN ? 3 : 5));
    tbl.push_back(v("to_after",   8'b0000_0000, 6'b000000, 0));

    drive(8'b1000_0000);
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].in);
      check(tbl[i].name, tbl[i].f, tbl[i].c);
    end

    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = $urandom_range(0, 7);
      in = '0;
      in[7] = (i == 0) || ($urandom_range(0, 49) == 0);
      case (sel)
        3: in[6] = 1'b1;
        4: in[5] = 1'b1;
        5, 7: in[4] = 1'b1;
        6: in[0] = 1'b1;
        default: ;
      endcase
      in[3] = ($urandom_range(0, 2) == 0);
      in[2] = $urandom_range(0, 1) != 0;
      in[1] = $urandom_range(0, 1) != 0;
      drive(in);
      ec = m_cnt;
      model_eval(in, ef);
      check("random", ef, ec);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
